// File: rtl/decode_queue_if.sv
// Front/back handshake bundle of the decode queue: fetch side pushes, execute side pops.
interface decode_queue_if #(
    parameter int CTRL_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [31:0]       in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_control;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic              out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_control, out_instr, out_pc, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_control, out_instr, out_pc, out_illegal
    );
endinterface

// File: rtl/decode_queue.sv
// Registered RV32I(+M/F) control decoder feeding a DEPTH-entry FIFO, with flush and a halt/drain FSM.
package decode_queue_pkg;
    typedef enum logic [2:0] {R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE, HALT_TYPE} encoding_t;
    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_SLT, ALU_SLTU, ALU_EQUAL, ALU_LT, ALU_LTU, ALU_MUL, ALU_MULH,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, ALU_FADD, ALU_FSUB
    } alu_op_t;
    typedef enum logic [2:0] {MEM_BYTE, MEM_HALF_WORD, MEM_FULL_WORD, MEM_BYTE_U, MEM_HALF_WORD_U} mem_size_t;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] block1;
        logic [6:0] opcode;
    } instruction_t;

    typedef struct packed {
        encoding_t  encoding;
        alu_op_t    alu_op;
        logic       alu_src;
        logic       alu_inv_res;
        logic       is_branch;
        logic       is_jump;
        logic       use_pc;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        mem_size_t  mem_size;
        logic       is_float;
        logic [4:0] write_back_id;
    } control_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOADFP = 7'b0000111;
    localparam logic [6:0] OP_STOREFP= 7'b0100111;
    localparam logic [6:0] OP_FP     = 7'b1010011;
    localparam logic [6:0] OP_HALT   = 7'b1111111;
endpackage

module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit MULDIV_EN = 1'b1,
    parameter bit FLOAT_EN  = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush_i,
    decode_queue_if.slave              q,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       halted
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

    typedef struct packed {
        control_t    ctrl;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        illegal;
    } entry_t;

    entry_t         mem_q [DEPTH];
    entry_t         head, wdata;
    logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    state_t         state_q, state_d;
    instruction_t   ins;
    control_t       dec;
    logic           bad, unsup, is_f, dec_illegal;
    logic           push, pop, flush_eff;

    function automatic alu_op_t base_alu(input logic [2:0] f3, input logic sra);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return sra ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    assign ins = q.in_instr;

    always_comb begin
        dec   = '0;
        bad   = 1'b0;
        unsup = 1'b0;
        is_f  = 1'b0;
        dec.write_back_id = ins.block1;
        case (ins.opcode)
            // LUI relies on the datapath treating rs1 as x0 for U-type
            OP_LUI:   begin dec.encoding = U_TYPE; dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
            OP_AUIPC: begin dec.encoding = U_TYPE; dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.use_pc = 1'b1; end
            OP_JAL:   begin dec.encoding = J_TYPE; dec.is_jump = 1'b1; dec.reg_write = 1'b1; dec.use_pc = 1'b1; end
            OP_JALR: begin
                dec.encoding = I_TYPE; dec.is_jump = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
                bad = (ins.funct3 != 3'b000);
            end
            OP_BRANCH: begin
                dec.encoding    = B_TYPE;
                dec.is_branch   = 1'b1;
                dec.alu_inv_res = ins.funct3[0];
                case (ins.funct3[2:1])
                    2'b00:   dec.alu_op = ALU_EQUAL;
                    2'b10:   dec.alu_op = ALU_LT;
                    2'b11:   dec.alu_op = ALU_LTU;
                    default: bad = 1'b1;
                endcase
            end
            OP_LOAD: begin
                dec.encoding = I_TYPE; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.mem_read = 1'b1;   dec.mem_to_reg = 1'b1;
                case (ins.funct3)
                    3'b000:  dec.mem_size = MEM_BYTE;
                    3'b001:  dec.mem_size = MEM_HALF_WORD;
                    3'b010:  dec.mem_size = MEM_FULL_WORD;
                    3'b100:  dec.mem_size = MEM_BYTE_U;
                    3'b101:  dec.mem_size = MEM_HALF_WORD_U;
                    default: bad = 1'b1;
                endcase
            end
            OP_STORE: begin
                dec.encoding = S_TYPE; dec.alu_src = 1'b1; dec.mem_write = 1'b1;
                case (ins.funct3)
                    3'b000:  dec.mem_size = MEM_BYTE;
                    3'b001:  dec.mem_size = MEM_HALF_WORD;
                    3'b010:  dec.mem_size = MEM_FULL_WORD;
                    default: bad = 1'b1;
                endcase
            end
            OP_IMM: begin
                dec.encoding = I_TYPE; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.alu_op   = base_alu(ins.funct3, ins.funct7[5]);
                if (ins.funct3 == 3'b001 && ins.funct7 != 7'b0) bad = 1'b1;
                if (ins.funct3 == 3'b101 && ins.funct7 != 7'b0 && ins.funct7 != 7'b0100000) bad = 1'b1;
            end
            OP_REG: begin
                dec.encoding  = R_TYPE;
                dec.reg_write = 1'b1;
                case (ins.funct7)
                    7'b0000000: dec.alu_op = base_alu(ins.funct3, 1'b0);
                    7'b0100000: begin
                        if (ins.funct3 == 3'b000)      dec.alu_op = ALU_SUB;
                        else if (ins.funct3 == 3'b101) dec.alu_op = ALU_SRA;
                        else                           bad = 1'b1;
                    end
                    7'b0000001: begin
                        case (ins.funct3)
                            3'b000:  dec.alu_op = ALU_MUL;
                            3'b001:  dec.alu_op = ALU_MULH;
                            3'b100:  dec.alu_op = ALU_DIV;
                            3'b101:  dec.alu_op = ALU_DIVU;
                            3'b110:  dec.alu_op = ALU_REM;
                            3'b111:  dec.alu_op = ALU_REMU;
                            default: bad = 1'b1;
                        endcase
                        if (!MULDIV_EN) bad = 1'b1;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OP_LOADFP, OP_STOREFP: begin
                is_f = 1'b1;
                dec.encoding = (ins.opcode == OP_LOADFP) ? I_TYPE : S_TYPE;
                if (ins.funct3 == 3'b010) unsup = 1'b1;
                else                      bad   = 1'b1;
            end
            OP_FP: begin
                is_f = 1'b1;
                dec.encoding = R_TYPE; dec.reg_write = 1'b1; dec.is_float = 1'b1;
                case (ins.funct7)
                    7'b0000000: dec.alu_op = ALU_FADD;
                    7'b0000100: dec.alu_op = ALU_FSUB;
                    7'b0001000, 7'b0001100, 7'b0101100: unsup = 1'b1;
                    7'b1010000: begin
                        if (ins.funct3 <= 3'b010) unsup = 1'b1;
                        else                      bad   = 1'b1;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OP_HALT: dec.encoding = HALT_TYPE;
            default: begin dec.encoding = R_TYPE; bad = 1'b1; end
        endcase
        // Parameter gating turns even datapath-less F ops into the plain NOP
        if (is_f && !FLOAT_EN) begin unsup = 1'b0; bad = 1'b1; end
        dec_illegal = bad | unsup;
        if (unsup) begin
            dec = '0;
        end else if (bad) begin
            dec         = '0;
            dec.alu_op  = ALU_AND;
            dec.alu_src = 1'b1;
        end
    end

    assign head      = mem_q[rd_q];
    assign wdata     = '{ctrl: dec, instr: q.in_instr, pc: q.in_pc, illegal: dec_illegal};
    assign flush_eff = flush_i && (state_q != S_HALTED);

    assign q.in_ready    = reset_n && (state_q == S_RUN) && (cnt_q != FULL);
    assign q.out_valid   = (cnt_q != '0) && (state_q != S_HALTED);
    assign q.out_control = q.out_valid ? head.ctrl    : '0;
    assign q.out_instr   = q.out_valid ? head.instr   : '0;
    assign q.out_pc      = q.out_valid ? head.pc      : '0;
    assign q.out_illegal = q.out_valid ? head.illegal : 1'b0;
    assign count         = cnt_q;
    assign halted        = (state_q == S_HALTED);

    assign push = q.in_valid && q.in_ready && !flush_i;
    assign pop  = q.out_valid && q.out_ready;

    always_comb begin
        wr_d  = wr_q + PW'(push);
        rd_d  = rd_q + PW'(pop);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        if (flush_eff) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (push && dec.encoding == HALT_TYPE) state_d = S_DRAIN;
            S_DRAIN: if (pop && head.ctrl.encoding == HALT_TYPE) state_d = S_HALTED;
            default: state_d = state_q;
        endcase
        if (flush_eff) state_d = S_RUN;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            state_q <= S_RUN;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Storage needs no reset: outputs are masked whenever the head is not valid
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= wdata;
    end
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode fields, FIFO order/backpressure, halt drain and flush.
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int CTRL_W = $bits(control_t);
    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_MUL  = 32'h022081B3;
    localparam logic [31:0] I_FADD = 32'h002081D3;
    localparam logic [31:0] I_FLW  = 32'h0000A107;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_UNK  = 32'h0000000B;
    localparam logic [31:0] I_HALT = 32'hFFFFFFFF;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush_i = 1'b0;
    logic [2:0] count, count2;
    logic halted, halted2;
    int total = 0;
    int bad = 0;

    decode_queue_if #(.CTRL_W(CTRL_W)) bus ();
    decode_queue_if #(.CTRL_W(CTRL_W)) bus2 ();

    decode_queue #(.DEPTH(4), .MULDIV_EN(1'b1), .FLOAT_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .flush_i(flush_i), .q(bus.slave), .count(count), .halted(halted));
    decode_queue #(.DEPTH(4), .MULDIV_EN(1'b0), .FLOAT_EN(1'b0)) dut_nomd (
        .clk(clk), .reset_n(reset_n), .flush_i(flush_i), .q(bus2.slave), .count(count2), .halted(halted2));

    control_t c, c2;
    assign c  = control_t'(bus.out_control);
    assign c2 = control_t'(bus2.out_control);

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_instr = '0; bus2.in_pc = '0; bus2.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready_low got=%0b exp=0", bus.in_ready); end
        step(); step();
        reset_n = 1'b1;
        step();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", bus.out_valid); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%0b exp=0", halted); end
        total++; if (bus.out_control !== '0 || bus.out_instr !== '0 || bus.out_pc !== '0 || bus.out_illegal !== 1'b0) begin
            bad++; $display("FAIL rst_outputs got ctrl=%0h instr=%0h pc=%0h ill=%0b exp all zero",
                bus.out_control, bus.out_instr, bus.out_pc, bus.out_illegal);
        end
    endtask

    task automatic test_addi();
        bus.in_valid = 1'b1; bus.in_instr = I_ADDI; bus.in_pc = 32'h0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL addi_no_comb_path got=%0b exp=0", bus.out_valid); end
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL addi_latency got=%0b exp=1", bus.out_valid); end
        total++; if (c.alu_op !== ALU_ADD) begin bad++; $display("FAIL addi_alu_op got=%0d exp=%0d", c.alu_op, ALU_ADD); end
        total++; if (c.alu_src !== 1'b1 || c.reg_write !== 1'b1) begin bad++; $display("FAIL addi_src_wr got=%0b%0b exp=11", c.alu_src, c.reg_write); end
        total++; if (c.encoding !== I_TYPE) begin bad++; $display("FAIL addi_encoding got=%0d exp=%0d", c.encoding, I_TYPE); end
        total++; if (c.write_back_id !== 5'd1) begin bad++; $display("FAIL addi_wb_id got=%0d exp=1", c.write_back_id); end
        total++; if (bus.out_illegal !== 1'b0) begin bad++; $display("FAIL addi_illegal got=%0b exp=0", bus.out_illegal); end
        total++; if (bus.out_instr !== I_ADDI) begin bad++; $display("FAIL addi_instr got=%0h exp=%0h", bus.out_instr, I_ADDI); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        total++; if (count !== 3'd0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL addi_pop got count=%0d valid=%0b exp 0 0", count, bus.out_valid); end
    endtask

    task automatic test_fill();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_instr = I_ADDI; bus.in_pc = 32'(4 * i);
            step();
        end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", count); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%0b exp=0", bus.in_ready); end
        bus.in_pc = 32'h10;
        step();
        bus.in_valid = 1'b0;
        total++; if (count !== 3'd4 || bus.out_pc !== 32'h0) begin bad++; $display("FAIL fill_stable got count=%0d pc=%0h exp 4 0", count, bus.out_pc); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * i)) begin
                bad++; $display("FAIL fill_order_%0d got valid=%0b pc=%0h exp 1 %0h", i, bus.out_valid, bus.out_pc, 4 * i);
            end
            step();
        end
        bus.out_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL fill_drained got=%0d exp=0", count); end
    endtask

    task automatic test_branch();
        bus.in_valid = 1'b1; bus.in_instr = I_BNE; bus.in_pc = 32'h40;
        step();
        bus.in_valid = 1'b0;
        total++; if (c.alu_op !== ALU_EQUAL) begin bad++; $display("FAIL bne_alu_op got=%0d exp=%0d", c.alu_op, ALU_EQUAL); end
        total++; if (c.is_branch !== 1'b1 || c.alu_inv_res !== 1'b1) begin bad++; $display("FAIL bne_flags got br=%0b inv=%0b exp 1 1", c.is_branch, c.alu_inv_res); end
        total++; if (c.encoding !== B_TYPE || c.reg_write !== 1'b0) begin bad++; $display("FAIL bne_enc got enc=%0d wr=%0b exp %0d 0", c.encoding, c.reg_write, B_TYPE); end
        bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    endtask

    task automatic test_muldiv();
        bus.in_valid = 1'b1; bus.in_instr = I_MUL; bus.in_pc = 32'h50;
        bus2.in_valid = 1'b1; bus2.in_instr = I_MUL; bus2.in_pc = 32'h50;
        step();
        bus.in_valid = 1'b0; bus2.in_valid = 1'b0;
        total++; if (c.alu_op !== ALU_MUL || c.reg_write !== 1'b1 || bus.out_illegal !== 1'b0) begin
            bad++; $display("FAIL mul_en got op=%0d wr=%0b ill=%0b exp %0d 1 0", c.alu_op, c.reg_write, bus.out_illegal, ALU_MUL);
        end
        total++; if (c2.alu_op !== ALU_AND || c2.reg_write !== 1'b0 || c2.alu_src !== 1'b1 || bus2.out_illegal !== 1'b1) begin
            bad++; $display("FAIL mul_gated got op=%0d wr=%0b src=%0b ill=%0b exp %0d 0 1 1", c2.alu_op, c2.reg_write, c2.alu_src, bus2.out_illegal, ALU_AND);
        end
        bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = I_FADD;
        bus2.in_valid = 1'b1; bus2.in_instr = I_FADD;
        step();
        bus.in_valid = 1'b0; bus2.in_valid = 1'b0;
        total++; if (c.alu_op !== ALU_FADD || c.is_float !== 1'b1 || bus.out_illegal !== 1'b0) begin
            bad++; $display("FAIL fadd_en got op=%0d f=%0b ill=%0b exp %0d 1 0", c.alu_op, c.is_float, bus.out_illegal, ALU_FADD);
        end
        total++; if (c2.alu_op !== ALU_AND || c2.is_float !== 1'b0 || bus2.out_illegal !== 1'b1) begin
            bad++; $display("FAIL fadd_gated got op=%0d f=%0b ill=%0b exp %0d 0 1", c2.alu_op, c2.is_float, bus2.out_illegal, ALU_AND);
        end
        bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    endtask

    task automatic test_illegal();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_instr = I_FLW; step(); bus.in_valid = 1'b0;
        total++; if (bus.out_control !== '0 || bus.out_illegal !== 1'b1) begin
            bad++; $display("FAIL flw_unsup got ctrl=%0h ill=%0b exp 0 1", bus.out_control, bus.out_illegal);
        end
        step();
        bus.in_valid = 1'b1; bus.in_instr = I_UNK; step(); bus.in_valid = 1'b0;
        total++; if (c.alu_op !== ALU_AND || c.alu_src !== 1'b1 || c.reg_write !== 1'b0 || c.encoding !== R_TYPE || bus.out_illegal !== 1'b1) begin
            bad++; $display("FAIL unknown_nop got op=%0d src=%0b wr=%0b enc=%0d ill=%0b exp %0d 1 0 0 1", c.alu_op, c.alu_src, c.reg_write, c.encoding, bus.out_illegal, ALU_AND);
        end
        step();
        bus.in_valid = 1'b1; bus.in_instr = I_LW; step(); bus.in_valid = 1'b0;
        total++; if (c.mem_read !== 1'b1 || c.mem_size !== MEM_FULL_WORD || c.write_back_id !== 5'd3 || bus.out_illegal !== 1'b0) begin
            bad++; $display("FAIL lw got rd=%0b sz=%0d wb=%0d ill=%0b exp 1 %0d 3 0", c.mem_read, c.mem_size, c.write_back_id, bus.out_illegal, MEM_FULL_WORD);
        end
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_instr = I_ADD; bus.in_pc = 32'h500;
        step();
        total++; if (count !== 3'd1 || bus.out_pc !== 32'h500) begin bad++; $display("FAIL b2b_first got count=%0d pc=%0h exp 1 500", count, bus.out_pc); end
        for (int i = 1; i < 3; i++) begin
            bus.in_pc = 32'h500 + 32'(4 * i);
            step();
            total++; if (count !== 3'd1 || bus.out_pc !== 32'h500 + 32'(4 * i)) begin
                bad++; $display("FAIL b2b_%0d got count=%0d pc=%0h exp 1 %0h", i, count, bus.out_pc, 32'h500 + 4 * i);
            end
        end
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL b2b_drain got=%0d exp=0", count); end
    endtask

    task automatic test_halt();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = I_ADD; bus.in_pc = 32'h100; step();
        bus.in_instr = I_HALT; bus.in_pc = 32'h104; step();
        bus.in_instr = I_ADD; bus.in_pc = 32'h108;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL halt_refuse got=%0b exp=0", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        total++; if (count !== 3'd2) begin bad++; $display("FAIL halt_count got=%0d exp=2", count); end
        bus.out_ready = 1'b1;
        total++; if (bus.out_pc !== 32'h100) begin bad++; $display("FAIL halt_pop0 got=%0h exp=100", bus.out_pc); end
        step();
        total++; if (bus.out_pc !== 32'h104 || c.encoding !== HALT_TYPE || halted !== 1'b0) begin
            bad++; $display("FAIL halt_head got pc=%0h enc=%0d halted=%0b exp 104 %0d 0", bus.out_pc, c.encoding, halted, HALT_TYPE);
        end
        step();
        bus.out_ready = 1'b0;
        total++; if (halted !== 1'b1 || bus.out_valid !== 1'b0 || count !== 3'd0) begin
            bad++; $display("FAIL halted_set got halted=%0b valid=%0b count=%0d exp 1 0 0", halted, bus.out_valid, count);
        end
        flush_i = 1'b1; bus.in_valid = 1'b1; step(); flush_i = 1'b0; bus.in_valid = 1'b0;
        total++; if (halted !== 1'b1 || bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL halted_flush got halted=%0b in_ready=%0b exp 1 0", halted, bus.in_ready);
        end
    endtask

    task automatic test_flush();
        reset_n = 1'b0;
        #1;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_mid got halted=%0b exp=0", halted); end
        step();
        reset_n = 1'b1;
        step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_instr = I_ADDI; bus.in_pc = 32'h200 + 32'(4 * i);
            step();
        end
        total++; if (count !== 3'd3) begin bad++; $display("FAIL flush_fill got=%0d exp=3", count); end
        bus.in_pc = 32'h300; flush_i = 1'b1;
        step();
        flush_i = 1'b0; bus.in_valid = 1'b0;
        total++; if (count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_empty got count=%0d valid=%0b ready=%0b exp 0 0 1", count, bus.out_valid, bus.in_ready);
        end
        step();
        total++; if (count !== 3'd0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_discard got count=%0d valid=%0b exp 0 0", count, bus.out_valid); end
        bus.in_valid = 1'b1; bus.in_instr = I_HALT; bus.in_pc = 32'h310; step(); bus.in_valid = 1'b0;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL drain_ready got=%0b exp=0", bus.in_ready); end
        flush_i = 1'b1; step(); flush_i = 1'b0;
        total++; if (bus.in_ready !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL drain_flush got ready=%0b count=%0d exp 1 0", bus.in_ready, count); end
        bus.in_valid = 1'b1; bus.in_instr = I_ADDI; bus.in_pc = 32'h400; step(); bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h400) begin bad++; $display("FAIL flush_reuse got valid=%0b pc=%0h exp 1 400", bus.out_valid, bus.out_pc); end
        bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_fill();
        test_branch();
        test_muldiv();
        test_illegal();
        test_back_to_back();
        test_halt();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
